// File: rtl/gpu_pkg.sv
// Shared GPU-path definitions: panel geometry, pixel format and the
// span_fill controller state encoding.
package gpu_pkg;

  localparam int GPU_DATA_W  = 8;    // coordinate width
  localparam int GPU_COLOR_W = 16;   // RGB565
  localparam int PANEL_X_MAX = 239;  // 240x240 LH154Q01, last column
  localparam int PANEL_Y_MAX = 239;  // last row

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SPAN = 3'd1,
    ST_FILL      = 3'd2,
    ST_REQ       = 3'd3,
    ST_FINISH    = 3'd4
  } fill_state_t;

endpackage

// File: rtl/span_clip.sv
// Combinational span conditioning: orders the two endpoints, clamps the
// right edge to the panel and flags spans that are entirely off-panel.
// Wrapped (underflowed) coordinates are treated as plain large values.
module span_clip
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = GPU_DATA_W,
  parameter int X_MAX      = PANEL_X_MAX,
  parameter int Y_MAX      = PANEL_Y_MAX
) (
  input  logic [DATA_WIDTH-1:0] i_x0,
  input  logic [DATA_WIDTH-1:0] i_x1,
  input  logic [DATA_WIDTH-1:0] i_y,
  output logic [DATA_WIDTH-1:0] o_xl,
  output logic [DATA_WIDTH-1:0] o_xr,
  output logic                  o_skip
);

  localparam logic [DATA_WIDTH-1:0] LP_X_MAX = DATA_WIDTH'(X_MAX);
  localparam logic [DATA_WIDTH-1:0] LP_Y_MAX = DATA_WIDTH'(Y_MAX);

  logic [DATA_WIDTH-1:0] w_lo;
  logic [DATA_WIDTH-1:0] w_hi;

  // Order endpoints, clamp the right edge, decide whether anything is visible.
  always_comb begin
    if (i_x0 <= i_x1) begin
      w_lo = i_x0;
      w_hi = i_x1;
    end else begin
      w_lo = i_x1;
      w_hi = i_x0;
    end
    o_xl   = w_lo;
    o_xr   = (w_hi > LP_X_MAX) ? LP_X_MAX : w_hi;
    o_skip = (i_y > LP_Y_MAX) || (w_lo > LP_X_MAX);
  end

endmodule

// File: rtl/span_fill.sv
// Span-to-pixel streamer behind the filled-circle span generator.
// Captures each span, clips it to the panel, emits one pixel per accepted
// beat and paces the generator with find_next until it reports completion.
module span_fill
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH  = GPU_DATA_W,
  parameter int COLOR_WIDTH = GPU_COLOR_W,
  parameter int X_MAX       = PANEL_X_MAX,
  parameter int Y_MAX       = PANEL_Y_MAX
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [COLOR_WIDTH-1:0] i_color,
  input  logic                   i_span_valid,
  input  logic [DATA_WIDTH-1:0]  i_span_x0,
  input  logic [DATA_WIDTH-1:0]  i_span_x1,
  input  logic [DATA_WIDTH-1:0]  i_span_y,
  input  logic                   i_span_done,
  output logic                   o_find_next,
  output logic                   o_pix_valid,
  input  logic                   i_pix_ready,
  output logic [DATA_WIDTH-1:0]  o_pix_x,
  output logic [DATA_WIDTH-1:0]  o_pix_y,
  output logic [COLOR_WIDTH-1:0] o_pix_color,
  output logic                   o_busy,
  output logic                   o_done
);

  fill_state_t            r_state;
  logic                   r_done_seen;
  logic [DATA_WIDTH-1:0]  r_xr;
  logic                   r_find_next;
  logic                   r_pix_valid;
  logic [DATA_WIDTH-1:0]  r_pix_x;
  logic [DATA_WIDTH-1:0]  r_pix_y;
  logic [COLOR_WIDTH-1:0] r_pix_color;
  logic                   r_busy;
  logic                   r_done;

  fill_state_t            w_state_next;
  logic                   w_done_seen_next;
  logic [DATA_WIDTH-1:0]  w_xr_next;
  logic                   w_find_next_next;
  logic                   w_pix_valid_next;
  logic [DATA_WIDTH-1:0]  w_pix_x_next;
  logic [DATA_WIDTH-1:0]  w_pix_y_next;
  logic [COLOR_WIDTH-1:0] w_pix_color_next;
  logic                   w_busy_next;
  logic                   w_done_next;

  logic [DATA_WIDTH-1:0]  w_clip_xl;
  logic [DATA_WIDTH-1:0]  w_clip_xr;
  logic                   w_clip_skip;
  logic                   w_done_any;

  span_clip #(
    .DATA_WIDTH (DATA_WIDTH),
    .X_MAX      (X_MAX),
    .Y_MAX      (Y_MAX)
  ) u_span_clip (
    .i_x0   (i_span_x0),
    .i_x1   (i_span_x1),
    .i_y    (i_span_y),
    .o_xl   (w_clip_xl),
    .o_xr   (w_clip_xr),
    .o_skip (w_clip_skip)
  );

  // Completion may be reported early (while the last span still fills) or
  // in the very cycle it is needed; either source ends the run.
  assign w_done_any = r_done_seen | i_span_done;

  // Next-state and registered-output decode.
  always_comb begin
    w_state_next     = r_state;
    w_done_seen_next = r_done_seen;
    w_xr_next        = r_xr;
    w_find_next_next = 1'b0;
    w_pix_valid_next = r_pix_valid;
    w_pix_x_next     = r_pix_x;
    w_pix_y_next     = r_pix_y;
    w_pix_color_next = r_pix_color;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // First span arrives unprompted, so no find_next here.
        if (i_start) begin
          w_pix_color_next = i_color;
          w_done_seen_next = 1'b0;
          w_busy_next      = 1'b1;
          w_state_next     = ST_WAIT_SPAN;
        end
      end

      ST_WAIT_SPAN: begin
        if (i_span_done) begin
          w_done_seen_next = 1'b1;
        end
        if (i_span_valid) begin
          w_xr_next = w_clip_xr;
          if (w_clip_skip) begin
            // Off-panel span: ask for the next one; pix_y is left alone so
            // the coordinate outputs never show an off-panel row.
            w_find_next_next = 1'b1;
            w_state_next     = ST_REQ;
          end else begin
            w_pix_x_next     = w_clip_xl;
            w_pix_y_next     = i_span_y;
            w_pix_valid_next = 1'b1;
            w_state_next     = ST_FILL;
          end
        end else if (w_done_any) begin
          w_done_next  = 1'b1;
          w_state_next = ST_FINISH;
        end
      end

      ST_FILL: begin
        if (i_span_done) begin
          w_done_seen_next = 1'b1;
        end
        if (i_pix_ready) begin
          if (r_pix_x == r_xr) begin
            w_pix_valid_next = 1'b0;
            if (w_done_any) begin
              w_done_next  = 1'b1;
              w_state_next = ST_FINISH;
            end else begin
              w_find_next_next = 1'b1;
              w_state_next     = ST_REQ;
            end
          end else begin
            w_pix_x_next = r_pix_x + DATA_WIDTH'(1);
          end
        end
      end

      ST_REQ: begin
        // find_next is high for this single cycle.
        if (i_span_done) begin
          w_done_seen_next = 1'b1;
        end
        w_state_next = ST_WAIT_SPAN;
      end

      ST_FINISH: begin
        // done is high for this single cycle; busy drops with it.
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_pix_valid_next = 1'b0;
        w_busy_next      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_done_seen <= 1'b0;
      r_xr        <= '0;
      r_find_next <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_done_seen <= w_done_seen_next;
      r_xr        <= w_xr_next;
      r_find_next <= w_find_next_next;
      r_pix_valid <= w_pix_valid_next;
      r_pix_x     <= w_pix_x_next;
      r_pix_y     <= w_pix_y_next;
      r_pix_color <= w_pix_color_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  assign o_find_next = r_find_next;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_x     = r_pix_x;
  assign o_pix_y     = r_pix_y;
  assign o_pix_color = r_pix_color;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_span_fill.sv
// Bench for span_fill: plays the span generator (midpoint circle spans and
// random spans), predicts the pixel stream from the clipping rules and checks
// every accepted beat, stalls, pacing and completion timing.
module tb_span_fill;

  logic        clk = 1'b0;
  logic        rst, start, sv, sdone, pr;
  logic [15:0] color;
  logic [7:0]  sx0, sx1, sy;
  logic        fn, pv, busy, done;
  logic [7:0]  px, py;
  logic [15:0] pc;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  span_fill dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_color      (color),
    .i_span_valid (sv),
    .i_span_x0    (sx0),
    .i_span_x1    (sx1),
    .i_span_y     (sy),
    .i_span_done  (sdone),
    .o_find_next  (fn),
    .o_pix_valid  (pv),
    .i_pix_ready  (pr),
    .o_pix_x      (px),
    .o_pix_y      (py),
    .o_pix_color  (pc),
    .o_busy       (busy),
    .o_done       (done)
  );

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] y;
  } span_t;

  span_t       spans[$];
  logic [31:0] exp_q[$];   // {x, y, color} in emission order

  int n_chk = 0, n_pass = 0;
  int acc_cnt = 0, vcyc_cnt = 0, fn_cnt = 0, done_cnt = 0;
  int last_acc_cyc = 0, done_cyc = 0, sv_cyc = 0, fn_cyc = 0;
  int row_cnt[256];
  int col_cnt[256];
  int ready_mode = 0, tog_base = 0;
  int b_acc, b_vcyc, b_fn, b_done;
  int b_row[256];
  int b_col[256];
  logic        stall_prev = 1'b0;
  logic [31:0] stall_xyc;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic span_t mk(input int a, input int b, input int c);
    span_t s;
    s.x0 = 8'(a);
    s.x1 = 8'(b);
    s.y  = 8'(c);
    return s;
  endfunction

  // Visible pixel count of a span: order, clamp right edge, drop off-panel.
  function automatic int model_count(input span_t s);
    int lo, hi;
    lo = (s.x0 < s.x1) ? int'(s.x0) : int'(s.x1);
    hi = (s.x0 < s.x1) ? int'(s.x1) : int'(s.x0);
    if (s.y > 239 || lo > 239) return 0;
    if (hi > 239) hi = 239;
    return hi - lo + 1;
  endfunction

  function automatic void model_push(input span_t s, input logic [15:0] c);
    int lo, n;
    lo = (s.x0 < s.x1) ? int'(s.x0) : int'(s.x1);
    n  = model_count(s);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(lo + i), s.y, c});
  endfunction

  // Software midpoint circle fill: four spans per octant step, 8-bit wrap.
  function automatic void circle(input int xc, input int yc, input int r);
    int x, y, err;
    x = r; y = 0; err = 0;
    spans.delete();
    while (x >= y) begin
      spans.push_back(mk(xc - x, xc + x, yc + y));
      spans.push_back(mk(xc - x, xc + x, yc - y));
      spans.push_back(mk(xc - y, xc + y, yc + x));
      spans.push_back(mk(xc - y, xc + y, yc - x));
      if (err <= 0) begin y++; err += 2 * y + 1; end
      if (err > 0) begin x--; err -= 2 * x + 1; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_acc = acc_cnt; b_vcyc = vcyc_cnt; b_fn = fn_cnt; b_done = done_cnt;
    for (int i = 0; i < 256; i++) begin
      b_row[i] = row_cnt[i];
      b_col[i] = col_cnt[i];
    end
  endtask

  task automatic recover();
    rst = 1'b1; sv = 1'b0; sdone = 1'b0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_start(input logic [15:0] c);
    tick();
    start = 1'b1; color = c;
    tick();
    start = 1'b0; color = 16'($urandom);
    @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    tick();
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    check("done_pulse_seen", int'(ok), 1);
    if (ok) begin
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end else begin
      recover();
    end
  endtask

  // Plays the generator for the current span list; dd = cycles from the last
  // span strobe to span_done (0 = same cycle).
  task automatic run_fill(input logic [15:0] c, input int dd, input int rmode);
    bit ok;
    ready_mode = rmode;
    foreach (spans[i]) model_push(spans[i], c);
    snap();
    do_start(c);
    repeat ($urandom_range(0, 2)) tick();
    for (int i = 0; i < spans.size(); i++) begin
      sx0 = spans[i].x0; sx1 = spans[i].x1; sy = spans[i].y;
      sv = 1'b1;
      sdone = (i == spans.size() - 1) && (dd == 0);
      tick();
      sv = 1'b0; sdone = 1'b0;
      sx0 = 8'($urandom); sx1 = 8'($urandom); sy = 8'($urandom);
      if (i != spans.size() - 1) begin
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
          @(negedge clk);
          if (fn) begin ok = 1'b1; break; end
        end
        check("find_next_seen", int'(ok), 1);
        if (!ok) begin recover(); return; end
        tick(); tick();
      end
    end
    if (dd > 0) begin
      repeat (dd - 1) tick();
      sdone = 1'b1;
      tick();
      sdone = 1'b0;
    end
    wait_done();
    check("pixels_left", exp_q.size(), 0);
    check("done_count", done_cnt - b_done, 1);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    int mn, mx;
    rst = 1'b1; start = 1'b0; sv = 1'b0; sdone = 1'b0; pr = 1'b1;
    color = '0; sx0 = '0; sx1 = '0; sy = '0;

    fork
      // Output monitor / scoreboard, sampled on the falling edge.
      forever begin
        @(negedge clk);
        if (rst) begin
          stall_prev = 1'b0;
        end else begin
          if (fn) begin fn_cnt++; fn_cyc = cyc; end
          if (done) begin done_cnt++; done_cyc = cyc; end
          if (sv) sv_cyc = cyc;
          if (stall_prev) begin
            check("stall_valid", int'(pv), 1);
            check("stall_x", int'(px), int'(stall_xyc[31:24]));
            check("stall_y", int'(py), int'(stall_xyc[23:16]));
            check("stall_color", int'(pc), int'(stall_xyc[15:0]));
          end
          if (pv) vcyc_cnt++;
          if (pv && pr) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            row_cnt[py]++;
            col_cnt[px]++;
            check("pix_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("pix_x", int'(px), int'(e[31:24]));
              check("pix_y", int'(py), int'(e[23:16]));
              check("pix_color", int'(pc), int'(e[15:0]));
            end
          end
          stall_prev = pv && !pr;
          stall_xyc  = {px, py, pc};
        end
      end
      // pix_ready driver: always-on, random, or 1-0-1-0 from tog_base.
      forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) pr = 1'b1;
        else if (ready_mode == 1) pr = ($urandom_range(0, 3) != 0);
        else pr = (((cyc - tog_base) % 2) == 0);
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_find_next", int'(fn), 0);
    check("rst_pix_valid", int'(pv), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pix_x", int'(px), 0);
    check("rst_pix_y", int'(py), 0);
    check("rst_pix_color", int'(pc), 0);
    tick();
    rst = 1'b0;

    // Hand-computed anchors for the clipping model.
    check("model_wrap_253_7", model_count(mk(253, 7, 120)), 233);
    check("model_single", model_count(mk(120, 120, 120)), 1);
    check("model_row_250", model_count(mk(10, 20, 250)), 0);
    check("model_reversed", model_count(mk(30, 10, 5)), 21);

    // Radius 0: four identical single-pixel spans, done right after the last.
    circle(120, 120, 0);
    check("r0_span_count", spans.size(), 4);
    run_fill(16'hF800, 1, 0);
    check("r0_pixels", acc_cnt - b_acc, 4);
    check("r0_row120", row_cnt[120] - b_row[120], 4);
    check("r0_col120", col_cnt[120] - b_col[120], 4);
    check("r0_find_next", fn_cnt - b_fn, 3);
    check("r0_done_latency", done_cyc, last_acc_cyc + 1);

    // Radius 5 on-panel with random backpressure.
    circle(120, 100, 5);
    run_fill(16'($urandom), int'($urandom_range(0, 6)), 1);
    for (int r = 95; r <= 105; r++) check("r5_row_covered", int'(row_cnt[r] > b_row[r]), 1);
    mn = 255; mx = 0;
    for (int x = 0; x < 256; x++) begin
      if (col_cnt[x] > b_col[x]) begin
        if (x < mn) mn = x;
        if (x > mx) mx = x;
      end
    end
    check("r5_min_x", mn, 115);
    check("r5_max_x", mx, 125);

    // Radius 5 near the left edge: wrapped endpoints clip to 7..239.
    circle(2, 120, 5);
    run_fill(16'h07E0, 2, 1);
    mx = 0;
    for (int x = 0; x < 256; x++) if (col_cnt[x] > b_col[x]) mx = x;
    check("wrap_max_x", mx, 239);
    check("wrap_row120", row_cnt[120] - b_row[120], 466);

    // Off-panel row: no pixels, find_next one cycle after capture.
    spans.delete();
    spans.push_back(mk(10, 20, 250));
    run_fill(16'h001F, 6, 0);
    check("skip_pixels", acc_cnt - b_acc, 0);
    check("skip_find_next", fn_cnt - b_fn, 1);
    check("skip_fn_latency", fn_cyc, sv_cyc + 1);

    // 6-pixel span with pix_ready alternating 1-0-1-0 from capture.
    spans.delete();
    model_push(mk(55, 50, 30), 16'hABCD);
    snap();
    ready_mode = 0;
    do_start(16'hABCD);
    ready_mode = 2;
    tog_base = cyc + 1;
    tick();
    sx0 = 8'd55; sx1 = 8'd50; sy = 8'd30; sv = 1'b1;
    tick();
    sv = 1'b0;
    repeat (14) tick();
    sdone = 1'b1;
    tick();
    sdone = 1'b0;
    wait_done();
    check("tog_valid_cycles", vcyc_cnt - b_vcyc, 12);
    check("tog_pixels", acc_cnt - b_acc, 6);
    check("tog_pixels_left", exp_q.size(), 0);
    exp_q.delete();
    ready_mode = 0;

    // Reset in the middle of a long span, then a clean fill.
    model_push(mk(0, 200, 10), 16'h1234);
    do_start(16'h1234);
    sx0 = 8'd0; sx1 = 8'd200; sy = 8'd10; sv = 1'b1;
    tick();
    sv = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_pix_valid", int'(pv), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_find_next", int'(fn), 0);
    check("mid_rst_pix_x", int'(px), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    spans.delete();
    spans.push_back(mk(9, 5, 7));
    run_fill(16'h5A5A, 0, 0);
    check("post_rst_pixels", acc_cnt - b_acc, 5);

    // Random span lists, random backpressure and completion timing.
    for (int t = 0; t < 8; t++) begin
      spans.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
        spans.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 239))
                                                       : int'($urandom_range(0, 255))));
      end
      run_fill(16'($urandom), int'($urandom_range(0, 20)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
